// File: rtl/dp_mem_be_if.sv
// Bus bundle for dp_mem_be: write port, read port, clear request and status.
// The master drives requests; the slave (the memory) returns read data and status.
interface dp_mem_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  clr_req;
    logic                  we;
    logic [NB-1:0]         wbe;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rd_err;
    logic                  busy;

    modport master (
        output clr_req, we, wbe, waddr, wdata, re, raddr,
        input  rdata, rvalid, rd_err, busy
    );

    modport slave (
        input  clr_req, we, wbe, waddr, wdata, re, raddr,
        output rdata, rvalid, rd_err, busy
    );
endinterface

// File: rtl/dp_mem_be.sv
// Simple dual-port RAM with byte enables, selectable read-during-write behaviour,
// registered read with valid/error strobes, and a hardware clear sweep after reset.
module dp_mem_be #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          RDW_MODE   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dp_mem_be_if.slave bus
);
    localparam int unsigned           NB       = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("dp_mem_be: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("dp_mem_be: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
    end

    typedef enum logic [0:0] {StClear, StReady} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  rvalid_q;
    logic                  rd_err_q;
    logic                  busy_q;

    // Storage is deliberately not reset; the clear sweep zeroes it.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  waddr_ok;
    logic                  raddr_ok;
    logic                  rdw_hit;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_be;

    assign waddr_ok = 32'(bus.waddr) < DEPTH;
    assign raddr_ok = 32'(bus.raddr) < DEPTH;
    assign rdw_hit  = bus.we && raddr_ok && (bus.waddr == bus.raddr);
    assign rd_word  = raddr_ok ? mem_q[bus.raddr] : '0;

    // Single write port shared between the sweep and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.waddr;
        mem_wdata = bus.wdata;
        mem_be    = bus.wbe;
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (bus.we && waddr_ok && (bus.wbe != '0)) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read-new mode forwards the enabled write lanes over the stored word.
    always_comb begin
        rdata_d = rd_word;
        if (RDW_MODE && rdw_hit) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.wbe[i]) begin
                    rdata_d[8*i +: 8] = bus.wdata[8*i +: 8];
                end
            end
        end
        if (!raddr_ok) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
            rd_err_q <= 1'b0;
            unique case (state_q)
                StClear: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LastAddr) begin
                        state_q    <= StReady;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b0;
                    end
                end
                StReady: begin
                    if (bus.re) begin
                        rdata_q  <= rdata_d;
                        rvalid_q <= 1'b1;
                        rd_err_q <= !raddr_ok;
                    end
                    if (bus.clr_req) begin
                        state_q    <= StClear;
                        clr_addr_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StClear;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rd_err = rd_err_q;
    assign bus.busy   = busy_q;

    a_err_needs_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        rd_err_q |-> rvalid_q);
    a_no_read_while_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StClear) |=> !rvalid_q);
endmodule
